// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the main-memory port arbiter: FSM states, grant ids,
// default widths and the one-hot to grant-id helper.
package mem_port_arbiter_pkg;

    localparam int ARB_ADDR_BITS    = 32;
    localparam int ARB_LINE_BITS    = 128;
    localparam int ARB_WORD_BITS    = 32;
    localparam int ARB_LINE_OFF     = 4;
    localparam int ARB_STARVE_LIMIT = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IC   = 2'd1,
        GNT_DC   = 2'd2,
        GNT_STB  = 2'd3
    } gnt_id_e;

    // Bit positions inside the one-hot grant vector.
    localparam int unsigned OH_IC  = 0;
    localparam int unsigned OH_DC  = 1;
    localparam int unsigned OH_STB = 2;

    function automatic gnt_id_e onehot_to_gnt(input logic [2:0] oh);
        gnt_id_e id;
        case (oh)
            3'b001:  id = GNT_IC;
            3'b010:  id = GNT_DC;
            3'b100:  id = GNT_STB;
            default: id = GNT_NONE;
        endcase
        return id;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational priority select for the memory port: drain escalation
// (full buffer or starvation), read-after-write protection, then dc > ic > stb.
module mem_arb_prio
    import mem_port_arbiter_pkg::*;
(
    input  logic       ic_req_i,
    input  logic       dc_req_i,
    input  logic       stb_req_i,
    input  logic       stb_full_i,
    input  logic       starve_hit_i,
    input  logic       line_match_i,
    output logic [2:0] grant_o
);

    always_comb begin
        grant_o = 3'b000;
        if (stb_req_i && (stb_full_i || starve_hit_i)) begin
            grant_o[OH_STB] = 1'b1;
        end else if (stb_req_i && dc_req_i && line_match_i) begin
            // A dcache fill must not read the line before the older store lands.
            grant_o[OH_STB] = 1'b1;
        end else if (dc_req_i) begin
            grant_o[OH_DC] = 1'b1;
        end else if (ic_req_i) begin
            grant_o[OH_IC] = 1'b1;
        end else if (stb_req_i) begin
            grant_o[OH_STB] = 1'b1;
        end else begin
            grant_o = 3'b000;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Main-memory port arbiter: one transaction at a time between icache fill,
// dcache fill and store-buffer drain; IDLE -> BUSY -> RESP handshake.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_BITS    = ARB_ADDR_BITS,
    parameter int LINE_BITS    = ARB_LINE_BITS,
    parameter int WORD_BITS    = ARB_WORD_BITS,
    parameter int LINE_OFF     = ARB_LINE_OFF,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 icReq,
    input  logic [ADDR_BITS-1:0] icAddr,
    output logic                 icAck,
    output logic [LINE_BITS-1:0] icData,
    input  logic                 dcReq,
    input  logic [ADDR_BITS-1:0] dcAddr,
    output logic                 dcAck,
    output logic [LINE_BITS-1:0] dcData,
    input  logic                 stbReq,
    input  logic [ADDR_BITS-1:0] stbAddr,
    input  logic [WORD_BITS-1:0] stbData,
    input  logic                 stbFull,
    output logic                 stbAck,
    output logic                 memReq,
    output logic                 memWe,
    output logic [ADDR_BITS-1:0] memAddr,
    output logic [WORD_BITS-1:0] memWData,
    input  logic                 memAck,
    input  logic [LINE_BITS-1:0] memRData
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e           state_q;
    gnt_id_e              gnt_q;
    logic [STARVE_W-1:0]  starve_q;
    logic [STARVE_W-1:0]  starve_d;
    logic                 icAck_q;
    logic                 dcAck_q;
    logic                 stbAck_q;
    logic [LINE_BITS-1:0] icData_q;
    logic [LINE_BITS-1:0] dcData_q;
    logic                 memReq_q;
    logic                 memWe_q;
    logic [ADDR_BITS-1:0] memAddr_q;
    logic [WORD_BITS-1:0] memWData_q;

    logic                 starve_hit;
    logic                 line_match;
    logic                 any_req;
    logic [2:0]           win_oh;
    gnt_id_e              win_id;
    logic [ADDR_BITS-1:0] win_addr;

    assign starve_hit = (starve_q == STARVE_W'(STARVE_LIMIT));
    assign line_match = (dcAddr[ADDR_BITS-1:LINE_OFF] == stbAddr[ADDR_BITS-1:LINE_OFF]);
    assign any_req    = icReq | dcReq | stbReq;

    mem_arb_prio u_prio (
        .ic_req_i     (icReq),
        .dc_req_i     (dcReq),
        .stb_req_i    (stbReq),
        .stb_full_i   (stbFull),
        .starve_hit_i (starve_hit),
        .line_match_i (line_match),
        .grant_o      (win_oh)
    );

    assign win_id = onehot_to_gnt(win_oh);

    always_comb begin
        win_addr = '0;
        case (win_id)
            GNT_IC:  win_addr = icAddr;
            GNT_DC:  win_addr = dcAddr;
            GNT_STB: win_addr = stbAddr;
            default: win_addr = '0;
        endcase
    end

    // Starvation only accrues in IDLE, where the drain actually competes.
    always_comb begin
        starve_d = starve_q;
        if (state_q == ST_IDLE) begin
            if (!stbReq || win_oh[OH_STB]) begin
                starve_d = '0;
            end else if (!starve_hit) begin
                starve_d = starve_q + STARVE_W'(1);
            end else begin
                starve_d = starve_q;
            end
        end else begin
            starve_d = starve_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= GNT_NONE;
            starve_q   <= '0;
            icAck_q    <= 1'b0;
            dcAck_q    <= 1'b0;
            stbAck_q   <= 1'b0;
            icData_q   <= '0;
            dcData_q   <= '0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWData_q <= '0;
        end else begin
            starve_q <= starve_d;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        state_q    <= ST_BUSY;
                        gnt_q      <= win_id;
                        memReq_q   <= 1'b1;
                        memWe_q    <= win_oh[OH_STB];
                        memAddr_q  <= win_addr;
                        memWData_q <= win_oh[OH_STB] ? stbData : '0;
                    end
                end
                ST_BUSY: begin
                    if (memAck) begin
                        state_q  <= ST_RESP;
                        memReq_q <= 1'b0;
                        memWe_q  <= 1'b0;
                        case (gnt_q)
                            GNT_IC: begin
                                icAck_q  <= 1'b1;
                                icData_q <= memRData;
                            end
                            GNT_DC: begin
                                dcAck_q  <= 1'b1;
                                dcData_q <= memRData;
                            end
                            GNT_STB: stbAck_q <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                ST_RESP: begin
                    state_q  <= ST_IDLE;
                    gnt_q    <= GNT_NONE;
                    icAck_q  <= 1'b0;
                    dcAck_q  <= 1'b0;
                    stbAck_q <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign icAck    = icAck_q;
    assign dcAck    = dcAck_q;
    assign stbAck   = stbAck_q;
    assign icData   = icData_q;
    assign dcData   = dcData_q;
    assign memReq   = memReq_q;
    assign memWe    = memWe_q;
    assign memAddr  = memAddr_q;
    assign memWData = memWData_q;

endmodule
